vc_pop_arbiter: RTL and testbench

//  Weighted arbiter between the VC0/VC1 FIFOs and the D0/D1 destination FIFOs.

---
 rtl/vc_pop_arbiter.sv | 129 ++++++++++++
 tb/tb_vc_pop_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_pop_arbiter.sv
// Weighted pop arbiter: pops VC0/VC1 words and pushes each to D0 or D1 by its destination bit.
// Optional grant statistics are enabled by defining VC_ARB_STATS_EN.
module vc_pop_arbiter #(
    parameter int DATA_SIZE  = 6,
    parameter int DEST_BIT   = 4,
    parameter int WEIGHT_VC0 = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 vc0_empty,
    input  logic                 vc1_empty,
    input  logic [DATA_SIZE-1:0] vc0_data,
    input  logic [DATA_SIZE-1:0] vc1_data,
    input  logic                 d0_pause,
    input  logic                 d1_pause,
    output logic                 pop_vc0,
    output logic                 pop_vc1,
    output logic                 push_d0,
    output logic                 push_d1,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 busy
`ifdef VC_ARB_STATS_EN
    ,
    output logic [7:0]           gnt_cnt0,
    output logic [7:0]           gnt_cnt1
`endif
);

    localparam logic [3:0] WMAX = 4'(WEIGHT_VC0);

    logic                 can_pop;
    logic                 vc0_rdy;
    logic                 vc1_rdy;
    logic                 gnt0;
    logic                 gnt1;
    logic [DATA_SIZE-1:0] s2_word;

    logic [3:0]           wcnt_d, wcnt_q;
    logic                 s1_valid_d, s1_valid_q;
    logic                 s1_src_d, s1_src_q;
    logic                 push_d0_d, push_d0_q;
    logic                 push_d1_d, push_d1_q;
    logic [DATA_SIZE-1:0] data_out_d, data_out_q;

    // Destination is unknown until the word is read, so either pause blocks all pops.
    always_comb begin
        can_pop = enable & ~d0_pause & ~d1_pause & ~reset;
        vc0_rdy = can_pop & ~vc0_empty;
        vc1_rdy = can_pop & ~vc1_empty;
        gnt1    = vc1_rdy & ~(vc0_rdy & (wcnt_q != WMAX));
        gnt0    = vc0_rdy & ~(vc1_rdy & (wcnt_q == WMAX));
    end

    always_comb begin
        wcnt_d = wcnt_q;
        if (gnt1) begin
            wcnt_d = 4'd0;
        end else if (enable & vc1_empty) begin
            wcnt_d = 4'd0;
        end else if (gnt0 && (wcnt_q != WMAX)) begin
            wcnt_d = wcnt_q + 4'd1;
        end
    end

    // Stage 1 remembers which FIFO was popped; its data arrives the following cycle.
    always_comb begin
        s1_valid_d = gnt0 | gnt1;
        s1_src_d   = gnt1;
        s2_word    = s1_src_q ? vc1_data : vc0_data;
        push_d0_d  = s1_valid_q & ~s2_word[DEST_BIT];
        push_d1_d  = s1_valid_q & s2_word[DEST_BIT];
        data_out_d = s1_valid_q ? s2_word : data_out_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_q     <= 4'd0;
            s1_valid_q <= 1'b0;
            s1_src_q   <= 1'b0;
            push_d0_q  <= 1'b0;
            push_d1_q  <= 1'b0;
            data_out_q <= '0;
        end else begin
            wcnt_q     <= wcnt_d;
            s1_valid_q <= s1_valid_d;
            s1_src_q   <= s1_src_d;
            push_d0_q  <= push_d0_d;
            push_d1_q  <= push_d1_d;
            data_out_q <= data_out_d;
        end
    end

    assign pop_vc0  = gnt0;
    assign pop_vc1  = gnt1;
    assign push_d0  = push_d0_q;
    assign push_d1  = push_d1_q;
    assign data_out = data_out_q;
    assign busy     = s1_valid_q | push_d0_q | push_d1_q;

`ifdef VC_ARB_STATS_EN
    logic [7:0] gnt_cnt0_d, gnt_cnt0_q;
    logic [7:0] gnt_cnt1_d, gnt_cnt1_q;

    // Counters saturate so a long run never wraps back to small values.
    always_comb begin
        gnt_cnt0_d = gnt_cnt0_q;
        gnt_cnt1_d = gnt_cnt1_q;
        if (gnt0 && (gnt_cnt0_q != 8'd255)) gnt_cnt0_d = gnt_cnt0_q + 8'd1;
        if (gnt1 && (gnt_cnt1_q != 8'd255)) gnt_cnt1_d = gnt_cnt1_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_cnt0_q <= 8'd0;
            gnt_cnt1_q <= 8'd0;
        end else begin
            gnt_cnt0_q <= gnt_cnt0_d;
            gnt_cnt1_q <= gnt_cnt1_d;
        end
    end

    assign gnt_cnt0 = gnt_cnt0_q;
    assign gnt_cnt1 = gnt_cnt1_q;
`else
    // Arbitration only; no statistics state.
`endif

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Bench for vc_pop_arbiter: grant table, directed multi-cycle sequences and random traffic
// checked against a queue-based model of the VC FIFOs and the two-cycle push schedule.
module tb_vc_pop_arbiter;

    localparam int DW     = 6;
    localparam int DBIT   = 4;
    localparam int WEIGHT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          vc0_empty;
    logic          vc1_empty;
    logic [DW-1:0] vc0_data;
    logic [DW-1:0] vc1_data;
    logic          d0_pause;
    logic          d1_pause;
    logic          pop_vc0;
    logic          pop_vc1;
    logic          push_d0;
    logic          push_d1;
    logic [DW-1:0] data_out;
    logic          busy;
`ifdef VC_ARB_STATS_EN
    logic [7:0]    gnt_cnt0;
    logic [7:0]    gnt_cnt1;
`endif

    vc_pop_arbiter #(.DATA_SIZE(DW), .DEST_BIT(DBIT), .WEIGHT_VC0(WEIGHT)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .vc0_empty (vc0_empty),
        .vc1_empty (vc1_empty),
        .vc0_data  (vc0_data),
        .vc1_data  (vc1_data),
        .d0_pause  (d0_pause),
        .d1_pause  (d1_pause),
        .pop_vc0   (pop_vc0),
        .pop_vc1   (pop_vc1),
        .push_d0   (push_d0),
        .push_d1   (push_d1),
        .data_out  (data_out),
        .busy      (busy)
`ifdef VC_ARB_STATS_EN
        ,
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] word;
    } sched_t;

    typedef struct packed {
        logic rst, en, p0, p1, e0, e1;
        logic g0, g1;
    } vec_t;

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            run0  = 0;
    int            m_cnt0 = 0;
    int            m_cnt1 = 0;
    logic [DW-1:0] vc0_q[$];
    logic [DW-1:0] vc1_q[$];
    sched_t        sched[$];
    int            grant_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive FIFO flags, compare against the model, advance the model.
    task automatic step();
        logic          g0, g1, e1, rdy;
        logic [DW-1:0] w0, w1;
        sched_t        s;
        w0 = '0;
        w1 = '0;
        vc0_empty = (vc0_q.size() == 0);
        vc1_empty = (vc1_q.size() == 0);
        e1 = vc1_empty;
        #1;
        rdy = !reset && enable && !d0_pause && !d1_pause;
        g0 = 1'b0;
        g1 = 1'b0;
        if (rdy) begin
            if (vc0_q.size() > 0 && vc1_q.size() > 0) begin
                if (run0 >= WEIGHT) g1 = 1'b1;
                else g0 = 1'b1;
            end else if (vc0_q.size() > 0) begin
                g0 = 1'b1;
            end else if (vc1_q.size() > 0) begin
                g1 = 1'b1;
            end
        end
        check("pop_vc0", 32'(pop_vc0), 32'(g0));
        check("pop_vc1", 32'(pop_vc1), 32'(g1));
        check("busy", 32'(busy), 32'(sched.size() > 0));
        if (sched.size() > 0 && sched[0].due == cyc) begin
            s = sched.pop_front();
            check("push_d0", 32'(push_d0), 32'(!s.word[DBIT]));
            check("push_d1", 32'(push_d1), 32'(s.word[DBIT]));
            check("data_out", 32'(data_out), 32'(s.word));
        end else begin
            check("push_d0_idle", 32'(push_d0), 32'd0);
            check("push_d1_idle", 32'(push_d1), 32'd0);
        end
`ifdef VC_ARB_STATS_EN
        check("gnt_cnt0", 32'(gnt_cnt0), 32'(m_cnt0));
        check("gnt_cnt1", 32'(gnt_cnt1), 32'(m_cnt1));
`endif
        if (g0) begin
            w0 = vc0_q.pop_front();
            sched.push_back('{cyc + 2, w0});
            grant_log.push_back(0);
            if (m_cnt0 < 255) m_cnt0++;
        end
        if (g1) begin
            w1 = vc1_q.pop_front();
            sched.push_back('{cyc + 2, w1});
            grant_log.push_back(1);
            if (m_cnt1 < 255) m_cnt1++;
        end
        if (reset) begin
            sched.delete();
            run0   = 0;
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else if (g1 || (enable && e1)) begin
            run0 = 0;
        end else if (g0) begin
            run0++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (g0) vc0_data = w0;
        if (g1) vc1_data = w1;
    endtask

    task automatic drain(input string name, input int max);
        int n;
        n = 0;
        while ((vc0_q.size() > 0 || vc1_q.size() > 0 || sched.size() > 0) && n < max) begin
            step();
            n++;
        end
        check({"drain_", name}, 32'(n < max), 32'd1);
    endtask

    task automatic reset_cycle();
        vc0_q.delete();
        vc1_q.delete();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    vec_t tv[10];
    int   exp_order[16];

    initial begin
        reset = 1'b1; enable = 1'b0; d0_pause = 1'b0; d1_pause = 1'b0;
        vc0_empty = 1'b1; vc1_empty = 1'b1; vc0_data = '0; vc1_data = '0;
        repeat (2) @(negedge clk);

        // rst en p0 p1 e0 e1 -> g0 g1, evaluated right after reset (weight counter 0)
        tv[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tv[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            reset = 1'b1; enable = 1'b0; d0_pause = 1'b0; d1_pause = 1'b0;
            vc0_empty = 1'b1; vc1_empty = 1'b1;
            @(negedge clk);
            reset = tv[i].rst; enable = tv[i].en; d0_pause = tv[i].p0; d1_pause = tv[i].p1;
            vc0_empty = tv[i].e0; vc1_empty = tv[i].e1;
            #1;
            check($sformatf("tbl%0d_pop_vc0", i), 32'(pop_vc0), 32'(tv[i].g0));
            check($sformatf("tbl%0d_pop_vc1", i), 32'(pop_vc1), 32'(tv[i].g1));
            @(negedge clk);
        end
        d0_pause = 1'b0; d1_pause = 1'b0;

        // Reset held with both VCs non-empty: nothing moves.
        vc0_q = '{6'h01, 6'h12, 6'h03};
        vc1_q = '{6'h21, 6'h32, 6'h23};
        reset = 1'b1; enable = 1'b1;
        repeat (4) step();
        check("t1_data_out", 32'(data_out), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        reset_cycle();

        // Two VC0 words to different destinations.
        vc0_q = '{6'h05, 6'h15};
        enable = 1'b1;
        drain("t2", 10);
        step();

        // Weighted interleave of two full VCs.
        reset_cycle();
        for (int i = 0; i < 8; i++) begin
            vc0_q.push_back(DW'($urandom_range(0, 63)));
            vc1_q.push_back(DW'($urandom_range(0, 63)));
        end
        grant_log.delete();
        drain("t3", 40);
        exp_order = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        check("t3_grants", 32'(grant_log.size()), 32'd16);
        for (int i = 0; i < 16 && i < grant_log.size(); i++)
            check($sformatf("t3_order%0d", i), 32'(grant_log[i]), 32'(exp_order[i]));

        // D1 pause mid-stream.
        reset_cycle();
        for (int i = 0; i < 10; i++) begin
            vc0_q.push_back(DW'($urandom_range(0, 63)));
            vc1_q.push_back(DW'($urandom_range(0, 63)));
        end
        repeat (3) step();
        d1_pause = 1'b1;
        repeat (3) step();
        d1_pause = 1'b0;
        drain("t4", 40);

        // Enable drop with one word in flight, then reset with one word in flight.
        reset_cycle();
        vc0_q.push_back(6'h1a);
        step();
        enable = 1'b0;
        repeat (3) step();
        check("t5_busy_idle", 32'(busy), 32'd0);
        vc0_q.push_back(6'h0b);
        repeat (2) step();
        enable = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; enable = 1'b0;
        repeat (3) step();
        check("t5_no_push_after_reset", 32'(push_d0 | push_d1), 32'd0);

        // Random traffic.
        enable = 1'b1;
        reset_cycle();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) vc0_q.push_back(DW'($urandom_range(0, 63)));
            if ($urandom_range(0, 2) == 0) vc1_q.push_back(DW'($urandom_range(0, 63)));
            enable   = ($urandom_range(0, 9) != 0);
            d0_pause = ($urandom_range(0, 7) == 0);
            d1_pause = ($urandom_range(0, 7) == 0);
            reset    = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0; enable = 1'b1; d0_pause = 1'b0; d1_pause = 1'b0;
        drain("rand", 400);

`ifdef VC_ARB_STATS_EN
        reset_cycle();
        for (int i = 0; i < 300; i++) vc0_q.push_back(DW'($urandom_range(0, 63)));
        for (int i = 0; i < 5; i++) vc1_q.push_back(DW'($urandom_range(0, 63)));
        drain("t6", 400);
        check("t6_gnt_cnt0", 32'(gnt_cnt0), 32'd255);
        check("t6_gnt_cnt1", 32'(gnt_cnt1), 32'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (bad=%0d)", bad);
        $fatal(1, "watchdog");
    end

endmodule
